// File: rtl/cdc_pkg.sv
// Shared types and constants for the source-side pulse transmitter.
package cdc_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_HOLD
  } tx_state_e;

  // Smallest hold that still covers receiver sync plus capture.
  localparam int unsigned MinGap = 2;

endpackage

// File: rtl/sync_fifo_reg.sv
// Register-array FIFO with combinational head read and registered occupancy.
module sync_fifo_reg #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned LvlW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic [W-1:0]    wdata,
  input  logic            pop,
  output logic [W-1:0]    rdata,
  output logic            full,
  output logic            empty,
  output logic [LvlW-1:0] level
);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic            do_push, do_pop;

  // Guard against over/underflow regardless of what the caller does.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level_q == LvlW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rptr_q];

  // Occupancy follows push/pop; a simultaneous pair leaves it unchanged.
  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  // Storage needs no reset; reset pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cdc_pulse_tx.sv
// Source-domain transmitter: buffers a valid/ready stream and emits spaced
// one-cycle tx_en pulses with tx_data held until the next pulse.
module cdc_pulse_tx
  import cdc_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 3,
  localparam int unsigned LvlW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            tx_en,
  output logic [W-1:0]    tx_data,
  output logic            busy,
  output logic [LvlW-1:0] level
);

  localparam int unsigned GapW = $clog2(GAP + 1);

  if (GAP < MinGap) begin : g_gap_check
    $error("cdc_pulse_tx: GAP must be at least %0d", MinGap);
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("cdc_pulse_tx: DEPTH must be a power of two >= 2");
  end

  tx_state_e       state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            tx_en_q;
  logic [W-1:0]    tx_data_q;
  logic            pop, push;
  logic            fifo_full, fifo_empty;
  logic [W-1:0]    fifo_rdata;

  // in_ready depends only on registered occupancy.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  sync_fifo_reg #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // State and gap counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= TX_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state: SEND lasts one cycle, HOLD counts GAP cycles down to 1.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) state_d = TX_SEND;
      end
      TX_SEND: begin
        gap_d   = GapW'(GAP);
        state_d = TX_HOLD;
      end
      TX_HOLD: begin
        gap_d = gap_q - GapW'(1);
        if (gap_q <= GapW'(1)) begin
          gap_d   = '0;
          state_d = fifo_empty ? TX_IDLE : TX_SEND;
        end
      end
      default: begin
        state_d = TX_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // Pop on every transition into SEND; the popped head is registered below.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      TX_IDLE: pop = !fifo_empty;
      TX_HOLD: pop = (gap_q <= GapW'(1)) && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // Output registers: tx_data only changes on the edge that raises tx_en.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_en_q <= pop;
      if (pop) tx_data_q <= fifo_rdata;
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;
  assign busy    = (level != '0) || (state_q != TX_IDLE);

endmodule
